wrr_input_arbiter: RTL and testbench

//  Parametrised packet-level weighted round-robin arbiter for the input stage of the switch pipeline.

---
 rtl/wrr_input_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_wrr_input_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_input_arbiter.sv
// wrr_fifo: first-word-fall-through FIFO, one per rx queue.
// Latency: a word written this cycle is visible on rd_dat next cycle.
// Backpressure: nearly_full at <=1 free entry; a write to a full FIFO is dropped unless a read frees space.
module wrr_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             nearly_full
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] NF_CNT   = (DEPTH_BITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  do_wr, do_rd;

  // Pointer and occupancy update; a full FIFO still takes a write when a read frees the slot.
  always_comb begin
    do_rd   = rd_en && (count_q != '0);
    do_wr   = wr_en && ((count_q != FULL_CNT) || do_rd);
    wptr_d  = do_wr ? wptr_q + DEPTH_BITS'(1) : wptr_q;
    rptr_d  = do_rd ? rptr_q + DEPTH_BITS'(1) : rptr_q;
    count_d = count_q;
    if (do_wr && !do_rd) count_d = count_q + (DEPTH_BITS+1)'(1);
    if (!do_wr && do_rd) count_d = count_q - (DEPTH_BITS+1)'(1);
  end

  // Pointer/occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wr_dat;
  end

  assign rd_dat      = mem[rptr_q];
  assign empty       = (count_q == '0);
  assign nearly_full = (count_q >= NF_CNT);
endmodule

// wrr_input_arbiter: packet-level weighted round-robin merge of NUM_QUEUES rx FIFOs onto one datapath.
// Latency: 1 cycle from FIFO pop to out_wr; one SELECT cycle (idle output) between packets.
// Backpressure: out_rdy gates pops so one word may follow out_rdy=0; in_rdy drops at <=1 free FIFO entry.
module wrr_input_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_QUEUES      = 8,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int WEIGHT_WIDTH    = 6,
  parameter int QW              = $clog2(NUM_QUEUES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
  input  logic [NUM_QUEUES-1:0]              in_wr,
  output logic [NUM_QUEUES-1:0]              in_rdy,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] queue_weight,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [CTRL_WIDTH-1:0]              out_ctrl,
  output logic                               out_wr,
  input  logic                               out_rdy,
  output logic [QW-1:0]                      grant_queue,
  output logic                               pkt_done
);
  localparam int WW = DATA_WIDTH + CTRL_WIDTH;

  typedef enum logic {SELECT, XFER} state_t;

  state_t                  state_q, state_d;
  logic [QW-1:0]           grant_q, grant_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [NUM_QUEUES-1:0]   seen_data_q, seen_data_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
  logic                    out_wr_q, out_wr_d;
  logic                    pkt_done_q, pkt_done_d;

  logic [NUM_QUEUES-1:0]   fifo_empty, fifo_nf, fifo_rd;
  logic [WW-1:0]           fifo_dat [NUM_QUEUES];
  logic [WEIGHT_WIDTH-1:0] weight   [NUM_QUEUES];
  logic [WW-1:0]           cur_dat;
  logic [CTRL_WIDTH-1:0]   cur_ctrl;
  logic                    hit;
  logic [QW-1:0]           hit_idx, cand;

  // Queue index grant+off, wrapping at NUM_QUEUES-1 -> 0 (works for non-power-of-two counts).
  function automatic logic [QW-1:0] wrap_idx(input logic [QW-1:0] base, input int off);
    return QW'((int'(base) + off) % NUM_QUEUES);
  endfunction

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
    assign weight[g] = queue_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    wrr_fifo #(.WIDTH(WW), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (in_wr[g]),
      .wr_dat      ({in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH], in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
      .rd_en       (fifo_rd[g]),
      .rd_dat      (fifo_dat[g]),
      .empty       (fifo_empty[g]),
      .nearly_full (fifo_nf[g])
    );
  end

  assign in_rdy = ~fifo_nf;

  // Round-robin search starting after the current grant; the current grant itself is checked last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      cand = wrap_idx(grant_q, k);
      if (!hit && (weight[cand] != '0) && !fifo_empty[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  // Arbitration FSM: pick a queue in SELECT, stream one whole packet in XFER.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    credit_d    = credit_q;
    seen_data_d = seen_data_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    out_wr_d    = 1'b0;
    pkt_done_d  = 1'b0;
    fifo_rd     = '0;
    cur_dat     = fifo_dat[grant_q];
    cur_ctrl    = cur_dat[WW-1 -: CTRL_WIDTH];
    case (state_q)
      SELECT: begin
        if ((credit_q != '0) && !fifo_empty[grant_q]) begin
          state_d = XFER;
        end else if (hit) begin
          grant_d  = hit_idx;
          credit_d = weight[hit_idx];
          state_d  = XFER;
        end else begin
          // Nothing eligible: leftover credit of an emptied queue is forfeited.
          credit_d = '0;
        end
      end
      XFER: begin
        // An empty FIFO mid-packet just pauses; the grant is never released before eop.
        if (out_rdy && !fifo_empty[grant_q]) begin
          fifo_rd[grant_q] = 1'b1;
          out_wr_d         = 1'b1;
          out_data_d       = cur_dat[DATA_WIDTH-1:0];
          out_ctrl_d       = cur_ctrl;
          if ((cur_ctrl != '0) && seen_data_q[grant_q]) begin
            seen_data_d[grant_q] = 1'b0;
            pkt_done_d           = 1'b1;
            credit_d             = (credit_q != '0) ? credit_q - WEIGHT_WIDTH'(1) : '0;
            state_d              = SELECT;
          end else if (cur_ctrl == '0) begin
            seen_data_d[grant_q] = 1'b1;
          end
        end
      end
      default: state_d = SELECT;
    endcase
  end

  // State and registered output; reset drops any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SELECT;
      grant_q     <= QW'(NUM_QUEUES - 1);
      credit_q    <= '0;
      seen_data_q <= '0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      out_wr_q    <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      credit_q    <= credit_d;
      seen_data_q <= seen_data_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      out_wr_q    <= out_wr_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_wr      = out_wr_q;
  assign pkt_done    = pkt_done_q;
  assign grant_queue = grant_q;
endmodule

// File: tb/tb_wrr_input_arbiter.sv
// Bench for wrr_input_arbiter: random packets per queue, expected output stream from a round-based WRR model.
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: sources honour in_rdy; out_rdy is held, toggled or randomised per test.
module tb_wrr_input_arbiter;
  localparam int NQ = 8;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int WW = 6;

  typedef logic [CW+DW-1:0] word_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NQ*DW-1:0] in_data;
  logic [NQ*CW-1:0] in_ctrl;
  logic [NQ-1:0]    in_wr;
  logic [NQ-1:0]    in_rdy;
  logic [NQ*WW-1:0] queue_weight;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy;
  logic [2:0]       grant_queue;
  logic             pkt_done;

  wrr_input_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .queue_weight (queue_weight),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .grant_queue  (grant_queue),
    .pkt_done     (pkt_done)
  );

  always #5 clk = ~clk;

  word_t src [NQ][$];   // words still to be pushed, per queue
  word_t mdl [NQ][$];   // model copy of every packet word, per queue
  int    mlen[NQ][$];   // packet lengths, per queue
  word_t exp_w[$];
  int    exp_g[$];
  bit    exp_e[$];

  int weights[NQ];
  int pushed[NQ];
  int checks, errors;
  int rdy_mode;
  int hold_q, hold_after, hold_left;
  int out_cnt, done_cnt, idle_gap, in_pkt_idle, pkts_started, cur_g, pkt_seq;
  bit in_pkt, gap_mode;

  task automatic set_weights();
    for (int q = 0; q < NQ; q++) queue_weight[q*WW +: WW] = WW'(weights[q]);
  endtask

  task automatic add_pkt(input int q, input int len);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w[DW-1:0]     = {8'(q), 16'(pkt_seq), 8'(i), 32'($urandom)};
      w[CW+DW-1:DW] = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      src[q].push_back(w);
      mdl[q].push_back(w);
    end
    mlen[q].push_back(len);
    pkt_seq++;
  endtask

  // Rounds over queues 0..NQ-1: each queue sends min(weight, packets left) packets per round.
  task automatic build_expected();
    int left[NQ];
    int len;
    bit any;
    for (int q = 0; q < NQ; q++) left[q] = mlen[q].size();
    do begin
      any = 1'b0;
      for (int q = 0; q < NQ; q++) begin
        for (int p = 0; p < weights[q] && left[q] > 0; p++) begin
          len = mlen[q].pop_front();
          left[q]--;
          any = 1'b1;
          for (int i = 0; i < len; i++) begin
            exp_w.push_back(mdl[q].pop_front());
            exp_g.push_back(q);
            exp_e.push_back(i == len - 1);
          end
        end
      end
    end while (any);
  endtask

  task automatic clear_bench();
    for (int q = 0; q < NQ; q++) begin
      src[q].delete();
      mdl[q].delete();
      mlen[q].delete();
      pushed[q] = 0;
    end
    exp_w.delete();
    exp_g.delete();
    exp_e.delete();
    in_wr = '0;
    out_cnt = 0; done_cnt = 0; idle_gap = 0; in_pkt_idle = 0; pkts_started = 0;
    in_pkt = 1'b0; gap_mode = 1'b0; hold_q = -1; hold_left = 0; hold_after = 0;
    rdy_mode = 0; out_rdy = 1'b1; cur_g = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_bench();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: check what the DUT shows, then drive sources and out_rdy for the next edge.
  task automatic step();
    word_t w;
    int    eg;
    bit    ee;
    bit    held;
    @(negedge clk);
    if (out_wr === 1'b1) begin
      checks++;
      if (out_rdy !== 1'b1) begin
        errors++;
        $display("FAIL rdy_skid: word emitted after pop edge with out_rdy=%b, required 1", out_rdy);
      end
      if (exp_w.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_word: got %h/%h from q%0d, required no word", out_ctrl, out_data, grant_queue);
      end else begin
        w  = exp_w.pop_front();
        eg = exp_g.pop_front();
        ee = exp_e.pop_front();
        checks++;
        if ({out_ctrl, out_data} !== w) begin
          errors++;
          $display("FAIL word: got %h/%h, required %h/%h", out_ctrl, out_data, w[CW+DW-1:DW], w[DW-1:0]);
        end
        checks++;
        if (grant_queue !== 3'(eg)) begin
          errors++;
          $display("FAIL grant: got %0d, required %0d", grant_queue, eg);
        end
        checks++;
        if (pkt_done !== ee) begin
          errors++;
          $display("FAIL pkt_done: got %b, required %b", pkt_done, ee);
        end
      end
      if (!in_pkt) begin
        if (gap_mode && pkts_started > 0) begin
          checks++;
          if (idle_gap != 1) begin
            errors++;
            $display("FAIL pkt_gap: got %0d idle cycles, required 1", idle_gap);
          end
        end
        pkts_started++;
      end
      in_pkt   = (pkt_done !== 1'b1);
      idle_gap = 0;
      cur_g    = int'(grant_queue);
      out_cnt++;
      if (pkt_done === 1'b1) done_cnt++;
    end else begin
      checks++;
      if (pkt_done !== 1'b0) begin
        errors++;
        $display("FAIL stray_done: pkt_done=%b with out_wr=%b, required 0", pkt_done, out_wr);
      end
      idle_gap++;
      if (in_pkt) begin
        in_pkt_idle++;
        checks++;
        if (grant_queue !== 3'(cur_g)) begin
          errors++;
          $display("FAIL grant_hold: got %0d mid-packet, required %0d", grant_queue, cur_g);
        end
      end
    end
    for (int q = 0; q < NQ; q++) begin
      held = (q == hold_q) && (pushed[q] >= hold_after) && (hold_left > 0);
      if (in_rdy[q] && src[q].size() > 0 && !held) begin
        w = src[q].pop_front();
        in_data[q*DW +: DW] = w[DW-1:0];
        in_ctrl[q*CW +: CW] = w[CW+DW-1:DW];
        in_wr[q] = 1'b1;
        pushed[q]++;
      end else begin
        in_wr[q] = 1'b0;
      end
    end
    if (hold_q >= 0 && pushed[hold_q] >= hold_after && hold_left > 0) hold_left--;
    case (rdy_mode)
      1:       out_rdy = ~out_rdy;
      2:       out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b1;
    endcase
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_w.size() > 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_w.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d words still outstanding, required 0", name, exp_w.size());
    end
    rdy_mode = 0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_bench();
    #1;
    checks++; if (out_wr !== 1'b0)      begin errors++; $display("FAIL rst_out_wr: got %b, required 0", out_wr); end
    checks++; if (out_data !== '0)      begin errors++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    checks++; if (out_ctrl !== '0)      begin errors++; $display("FAIL rst_out_ctrl: got %h, required 0", out_ctrl); end
    checks++; if (pkt_done !== 1'b0)    begin errors++; $display("FAIL rst_pkt_done: got %b, required 0", pkt_done); end
    checks++; if (grant_queue !== 3'd7) begin errors++; $display("FAIL rst_grant: got %0d, required 7", grant_queue); end
    checks++; if (in_rdy !== {NQ{1'b1}}) begin errors++; $display("FAIL rst_in_rdy: got %b, required all 1", in_rdy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rr_basic();
    do_reset();
    for (int q = 0; q < NQ; q++) weights[q] = 1;
    set_weights();
    for (int p = 0; p < 2; p++) for (int q = 0; q < 3; q++) add_pkt(q, 4);
    build_expected();
    gap_mode = 1'b1;
    drain(400, "rr_basic");
    checks++;
    if (done_cnt != 6) begin errors++; $display("FAIL rr_basic_done: got %0d packets, required 6", done_cnt); end
  endtask

  task automatic test_weighted();
    do_reset();
    for (int q = 0; q < NQ; q++) weights[q] = 1;
    weights[2] = 3;
    set_weights();
    for (int q = 0; q < NQ; q++)
      for (int p = 0; p < ((q == 2) ? 6 : 2); p++) add_pkt(q, $urandom_range(2, 5));
    build_expected();
    gap_mode = 1'b1;
    drain(1500, "weighted");
    checks++;
    if (done_cnt != 20) begin errors++; $display("FAIL weighted_done: got %0d packets, required 20", done_cnt); end
  endtask

  task automatic test_zero_weight();
    do_reset();
    for (int q = 0; q < NQ; q++) weights[q] = 1;
    weights[1] = 0;
    set_weights();
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, $urandom_range(2, 6));
      add_pkt(1, $urandom_range(2, 6));
    end
    build_expected();
    drain(600, "zero_weight");
    checks++;
    if (in_rdy[1] !== 1'b0) begin errors++; $display("FAIL zero_weight_rdy1: got %b, required 0", in_rdy[1]); end
    checks++;
    if (in_rdy[0] !== 1'b1) begin errors++; $display("FAIL zero_weight_rdy0: got %b, required 1", in_rdy[0]); end
  endtask

  task automatic test_rdy_toggle();
    int total = 0;
    int len;
    do_reset();
    for (int q = 0; q < NQ; q++) weights[q] = 1;
    set_weights();
    for (int p = 0; p < 2; p++) begin
      len = $urandom_range(3, 6); add_pkt(0, len); total += len;
      len = $urandom_range(3, 6); add_pkt(5, len); total += len;
    end
    build_expected();
    rdy_mode = 1;
    drain(600, "rdy_toggle");
    checks++;
    if (out_cnt != total) begin errors++; $display("FAIL rdy_toggle_count: got %0d words, required %0d", out_cnt, total); end
  endtask

  task automatic test_mid_stall();
    do_reset();
    for (int q = 0; q < NQ; q++) weights[q] = 1;
    set_weights();
    add_pkt(3, 8);
    add_pkt(4, 3);
    hold_q = 3; hold_after = 3; hold_left = 9;
    build_expected();
    drain(400, "mid_stall");
    checks++;
    if (in_pkt_idle < 5) begin errors++; $display("FAIL mid_stall_idle: got %0d idle cycles in packet, required >=5", in_pkt_idle); end
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL mid_stall_done: got %0d packets, required 2", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    for (int q = 0; q < NQ; q++) weights[q] = 1;
    set_weights();
    add_pkt(0, 6);
    build_expected();
    while (out_cnt < 3 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (out_cnt != 3) begin errors++; $display("FAIL reset_mid_reach: got %0d words, required 3", out_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (out_wr !== 1'b0)       begin errors++; $display("FAIL reset_mid_out_wr: got %b, required 0", out_wr); end
    checks++; if (grant_queue !== 3'd7)  begin errors++; $display("FAIL reset_mid_grant: got %0d, required 7", grant_queue); end
    checks++; if (in_rdy !== {NQ{1'b1}}) begin errors++; $display("FAIL reset_mid_in_rdy: got %b, required all 1", in_rdy); end
    clear_bench();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // Flushed FIFOs: any word appearing now is flagged as extra.
    repeat (10) step();
    add_pkt(5, 3);
    add_pkt(0, 3);
    build_expected();
    drain(300, "reset_mid");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int q = 0; q < NQ; q++) weights[q] = $urandom_range(0, 3);
      set_weights();
      for (int q = 0; q < NQ; q++)
        for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(q, $urandom_range(2, 6));
      build_expected();
      rdy_mode = 2;
      drain(4000, "random");
    end
  endtask

  initial begin
    checks = 0; errors = 0; pkt_seq = 0;
    in_data = '0; in_ctrl = '0; in_wr = '0; queue_weight = '0; out_rdy = 1'b1; reset = 1'b1;
    test_reset();
    test_rr_basic();
    test_weighted();
    test_zero_weight();
    test_rdy_toggle();
    test_mid_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
